branch_pred_ctrl: RTL and testbench
===================================

# branch_pred_ctrl

Branch prediction and redirect controller for the 5-stage pipelined CPU. It looks up a 2-bit saturating-counter branch history table (BHT) for the branch in ID and resolves predictions against the branch outcome computed in EX. It drives the PC mux select and the IF/ID and ID/EX flush lines. It replaces the always-not-taken PC source path and sits between the ID/EX stages and the PC register.

## Interface
- IDX_W, 4: BHT index width; the table has 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  load-use stall from the hazard unit; PC and IF/ID are frozen.
- id_valid, id_is_branch  in  1 each  ID holds a valid B-type instruction.
- id_pc  in  32  PC of the ID instruction.
- ex_valid, ex_is_branch, ex_jump  in  1 each  EX holds a valid branch or a jal/jalr.
- ex_pc  in  32  PC of the EX instruction.
- ex_taken  in  1  resolved branch condition from EX.
- ex_pred_taken  in  1  pred_taken value carried through ID/EX.
- pc_sel  out  2  00 = pc+4, 01 = ID branch target, 10 = EX target, 11 = EX pc+4.
- pred_taken  out  1  ID prediction; latched into ID/EX.
- flush_ifid, flush_idex  out  1 each  bubble-insert controls.
- branch_cnt, mispred_cnt  out  32 each  present only with BRANCH_STATS_EN.

## Operation
- BHT entries: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken. Reset value of every entry is 01.
- The ID prediction is bht[id_pc[IDX_W+1:2]][1], gated by id_valid & id_is_branch.
- ex_redirect = ex_valid & (ex_jump | (ex_is_branch & (ex_taken != ex_pred_taken))).
- Priority, highest first:
  - ex_redirect: pc_sel = 10 if ex_jump or ex_taken, else 11. flush_ifid = flush_idex = 1. pred_taken = 0.
  - ID prediction taken and stall = 0: pc_sel = 01, flush_ifid = 1, pred_taken = 1.
  - Otherwise: pc_sel = 00, no flush, pred_taken = 0.
- stall suppresses only the ID redirect. An EX redirect overrides stall.
- BHT update on ex_valid & ex_is_branch: the entry at ex_pc[IDX_W+1:2] increments on ex_taken and decrements otherwise, saturating at 11 and 00. Jumps never update the BHT.
- Aliasing is accepted: PCs with equal index bits share an entry.

## Timing
- pc_sel, pred_taken and the flush outputs are combinational from the inputs and the current BHT state, with zero-cycle latency.
- BHT writes occur on the rising clk edge.
- When ID and EX touch the same index in the same cycle, the ID read returns the pre-update value. There is no bypass.
- Reset (any time, asynchronous): all BHT entries go to 01 and the statistics counters clear to 0. With all valid inputs low, outputs are pc_sel = 00, pred_taken = 0 and both flushes = 0.
- A mispredict costs 2 bubbles. A correctly predicted taken branch costs 1 bubble.

## Configuration
- BRANCH_STATS_EN defined:
  - branch_cnt increments once per EX branch update.
  - mispred_cnt increments once per branch mispredict (jumps are not counted).
  - Both counters are 32-bit, wrap at 2^32, and clear on reset.
- BRANCH_STATS_EN undefined: the counters and their ports are absent. All other behaviour is identical.

## Structure
- Shared package holds the PC_SEL_* encodings (pc4, id_tgt, ex_tgt, ex_pc4) and the BHT state constants (SNT, WNT, WT, ST).
- Sub-module bp_bht holds the counter array:
  - one asynchronous read port and one clocked saturating-update port;
  - parameter IDX_W;
  - asynchronous active-low reset to WNT.
- Redirect priority logic stays in branch_pred_ctrl.

## Test plan
- Branch history and redirect:
  - After reset, ID branch at id_pc = 0x40 -> pred_taken = 0, pc_sel = 00, no flush.
  - EX branch at 0x40 with ex_taken = 1, ex_pred_taken = 0 -> pc_sel = 10, both flushes = 1, entry 0 goes 01 -> 10.
  - Next ID branch at 0x40 -> pc_sel = 01, flush_ifid = 1.
- Saturation and aliasing:
  - Three taken resolutions at 0x40 -> entry 11, and a fourth taken resolution leaves it at 11.
  - One not-taken resolution at 0x80 (aliases index 0) -> entry 10, and ID at 0x40 still predicts taken.
- Simultaneous events: EX branch with ex_pred_taken = 1, ex_taken = 0, while ID holds a predicted-taken branch -> pc_sel = 11, both flushes = 1, pred_taken = 0.
- Stall interaction:
  - stall = 1 with a predicted-taken branch in ID -> pc_sel = 00, no flush.
  - stall = 1 with ex_jump = 1 -> pc_sel = 10, both flushes = 1.
- Read/write collision: ID and EX both at index 3 with the entry at 01 and ex_taken = 1 -> this cycle pred_taken = 0, next cycle the entry reads 10.
- Reset mid-operation: after training, pulse rst_n low mid-cycle -> all entries read 01 immediately. With BRANCH_STATS_EN, branch_cnt and mispred_cnt both read 0.

Source files
------------

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared encodings for the branch predictor: PC mux selects, BHT counter states,
// and the saturating counter update used by the history table.
package branch_pred_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_SEL_PC4    = 2'b00,
        PC_SEL_ID_TGT = 2'b01,
        PC_SEL_EX_TGT = 2'b10,
        PC_SEL_EX_PC4 = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Two-bit counter step toward the resolved direction, pinned at both ends.
    function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cur == ST) ? cur : cur + 2'd1;
        end else begin
            nxt = (cur == SNT) ? cur : cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Pipeline-side bundle between ID/EX and the branch predictor.
// Statistics counters exist only when BRANCH_STATS_EN is defined.
interface branch_pred_ctrl_if;

    logic        stall;
    logic        id_valid;
    logic        id_is_branch;
    logic [31:0] id_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [1:0]  pc_sel;
    logic        pred_taken;
    logic        flush_ifid;
    logic        flush_idex;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
`endif

    modport master (
        output stall, id_valid, id_is_branch, id_pc,
        output ex_valid, ex_is_branch, ex_jump, ex_pc, ex_taken, ex_pred_taken,
`ifdef BRANCH_STATS_EN
        input  branch_cnt, mispred_cnt,
`endif
        input  pc_sel, pred_taken, flush_ifid, flush_idex
    );

    modport slave (
        input  stall, id_valid, id_is_branch, id_pc,
        input  ex_valid, ex_is_branch, ex_jump, ex_pc, ex_taken, ex_pred_taken,
`ifdef BRANCH_STATS_EN
        output branch_cnt, mispred_cnt,
`endif
        output pc_sel, pred_taken, flush_ifid, flush_idex
    );

endinterface

// File: rtl/branch_pred_ctrl_bp_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters with one
// asynchronous read port and one clocked update port.
module bp_bht
    import branch_pred_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] ctr [ENTRIES];

    // Every entry starts weakly not-taken so one taken resolution flips it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= WNT;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
        end
    end

    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch prediction and redirect controller: BHT lookup in ID, resolution in EX.
// Define BRANCH_STATS_EN to add branch and mispredict counters.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_pred_ctrl_if.slave  bus
);

    logic [1:0] id_ctr;
    logic       id_pred;
    logic       ex_update;
    logic       ex_mispred;
    logic       ex_redirect;
    logic       unused_pc_bits;

    bp_bht #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (bus.id_pc[IDX_W+1:2]),
        .rd_ctr    (id_ctr),
        .upd_en    (ex_update),
        .upd_idx   (bus.ex_pc[IDX_W+1:2]),
        .upd_taken (bus.ex_taken)
    );

    assign unused_pc_bits = ^{bus.id_pc[31:IDX_W+2], bus.id_pc[1:0],
                              bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0], id_ctr[0]};

    assign id_pred     = bus.id_valid & bus.id_is_branch & id_ctr[1];
    assign ex_update   = bus.ex_valid & bus.ex_is_branch;
    assign ex_mispred  = ex_update & (bus.ex_taken != bus.ex_pred_taken);
    assign ex_redirect = (bus.ex_valid & bus.ex_jump) | ex_mispred;

    // EX redirect outranks everything, including stall; stall only holds back ID.
    always_comb begin
        bus.pc_sel     = PC_SEL_PC4;
        bus.pred_taken = 1'b0;
        bus.flush_ifid = 1'b0;
        bus.flush_idex = 1'b0;
        if (ex_redirect) begin
            bus.pc_sel     = (bus.ex_jump | bus.ex_taken) ? PC_SEL_EX_TGT : PC_SEL_EX_PC4;
            bus.flush_ifid = 1'b1;
            bus.flush_idex = 1'b1;
        end else if (id_pred && !bus.stall) begin
            bus.pc_sel     = PC_SEL_ID_TGT;
            bus.flush_ifid = 1'b1;
            bus.pred_taken = 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.branch_cnt  <= '0;
            bus.mispred_cnt <= '0;
        end else begin
            if (ex_update) begin
                bus.branch_cnt <= bus.branch_cnt + 32'd1;
            end
            if (ex_mispred) begin
                bus.mispred_cnt <= bus.mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed plan steps then random traffic
// against an integer-array model of the history table.
module tb_branch_pred_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_pred_ctrl_if bus ();

    branch_pred_ctrl #(
        .IDX_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int model [16];
    int unsigned exp_branch_cnt;
    int unsigned exp_mispred_cnt;

    function automatic void resetModel();
        for (int i = 0; i < 16; i++) model[i] = 1;
        exp_branch_cnt  = 0;
        exp_mispred_cnt = 0;
    endfunction

    task automatic driveIdle();
        bus.stall = 0; bus.id_valid = 0; bus.id_is_branch = 0; bus.id_pc = '0;
        bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_jump = 0; bus.ex_pc = '0;
        bus.ex_taken = 0; bus.ex_pred_taken = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] es, input logic ept,
                               input logic efi, input logic efe);
        checks++;
        assert (bus.pc_sel === es) else begin
            errors++; $error("[TB] FAIL %s pc_sel got %b expected %b", tag, bus.pc_sel, es);
        end
        checks++;
        assert (bus.pred_taken === ept) else begin
            errors++; $error("[TB] FAIL %s pred_taken got %b expected %b", tag, bus.pred_taken, ept);
        end
        checks++;
        assert (bus.flush_ifid === efi) else begin
            errors++; $error("[TB] FAIL %s flush_ifid got %b expected %b", tag, bus.flush_ifid, efi);
        end
        checks++;
        assert (bus.flush_idex === efe) else begin
            errors++; $error("[TB] FAIL %s flush_idex got %b expected %b", tag, bus.flush_idex, efe);
        end
    endtask

    task automatic checkEntry(input string tag, input int idx, input logic [1:0] exp);
        checks++;
        assert (dut.u_bht.ctr[idx] === exp) else begin
            errors++; $error("[TB] FAIL %s entry %0d got %b expected %b", tag, idx, dut.u_bht.ctr[idx], exp);
        end
    endtask

    task automatic checkTable(input string tag);
        for (int i = 0; i < 16; i++) checkEntry(tag, i, 2'(model[i]));
    endtask

    task automatic checkStats(input string tag);
`ifdef BRANCH_STATS_EN
        checks++;
        assert (bus.branch_cnt === exp_branch_cnt) else begin
            errors++; $error("[TB] FAIL %s branch_cnt got %0d expected %0d", tag, bus.branch_cnt, exp_branch_cnt);
        end
        checks++;
        assert (bus.mispred_cnt === exp_mispred_cnt) else begin
            errors++; $error("[TB] FAIL %s mispred_cnt got %0d expected %0d", tag, bus.mispred_cnt, exp_mispred_cnt);
        end
`else
        $display("[TB] %s statistics not built", tag);
`endif
    endtask

    // Drive one cycle, check the combinational decision, let the edge commit, go idle.
    task automatic applyStimulus(input string tag, input logic st,
                                 input logic idv, input logic idb, input logic [31:0] idpc,
                                 input logic exv, input logic exb, input logic exj,
                                 input logic [31:0] expc, input logic ext, input logic expt);
        int id_idx;
        int ex_idx;
        bit redirect;
        bit id_pred;
        logic [1:0] es;
        logic ept, efi, efe;
        @(negedge clk);
        bus.stall = st; bus.id_valid = idv; bus.id_is_branch = idb; bus.id_pc = idpc;
        bus.ex_valid = exv; bus.ex_is_branch = exb; bus.ex_jump = exj; bus.ex_pc = expc;
        bus.ex_taken = ext; bus.ex_pred_taken = expt;
        #1;
        id_idx   = (idpc / 4) % 16;
        ex_idx   = (expc / 4) % 16;
        redirect = exv && (exj || (exb && (ext != expt)));
        id_pred  = idv && idb && (model[id_idx] >= 2);
        if (redirect) begin
            es = (exj || ext) ? 2'b10 : 2'b11; ept = 0; efi = 1; efe = 1;
        end else if (id_pred && !st) begin
            es = 2'b01; ept = 1; efi = 1; efe = 0;
        end else begin
            es = 2'b00; ept = 0; efi = 0; efe = 0;
        end
        checkOutput(tag, es, ept, efi, efe);
        if (exv && exb) begin
            if (ext) model[ex_idx] = (model[ex_idx] == 3) ? 3 : model[ex_idx] + 1;
            else     model[ex_idx] = (model[ex_idx] == 0) ? 0 : model[ex_idx] - 1;
            exp_branch_cnt++;
            if (ext != expt) exp_mispred_cnt++;
        end
        @(posedge clk);
        #1;
        driveIdle();
    endtask

    initial begin
        driveIdle();
        resetModel();
        #12;
        checkOutput("reset_idle", 2'b00, 0, 0, 0);
        checkTable("reset_table");
        checkStats("reset_stats");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("id_cold", 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        applyStimulus("ex_first_taken", 0, 0, 0, 0, 1, 1, 0, 32'h40, 1, 0);
        checkEntry("entry0_weak_taken", 0, 2'b10);
        applyStimulus("id_predict_taken", 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) applyStimulus("ex_taken_train", 0, 0, 0, 0, 1, 1, 0, 32'h40, 1, 1);
        checkEntry("entry0_strong", 0, 2'b11);
        applyStimulus("ex_taken_sat", 0, 0, 0, 0, 1, 1, 0, 32'h40, 1, 1);
        checkEntry("entry0_saturated", 0, 2'b11);
        applyStimulus("alias_not_taken", 0, 0, 0, 0, 1, 1, 0, 32'h80, 0, 1);
        checkEntry("entry0_after_alias", 0, 2'b10);
        applyStimulus("id_after_alias", 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);

        applyStimulus("simultaneous", 0, 1, 1, 32'h40, 1, 1, 0, 32'h80, 0, 1);
        applyStimulus("retrain_taken", 0, 0, 0, 0, 1, 1, 0, 32'h40, 1, 0);
        applyStimulus("stall_id_pred", 1, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        applyStimulus("stall_ex_jump", 1, 1, 1, 32'h40, 1, 0, 1, 32'h40, 0, 0);
        checkTable("jump_no_update");

        applyStimulus("collision_same_cycle", 0, 1, 1, 32'h0C, 1, 1, 0, 32'h0C, 1, 1);
        checkEntry("entry3_after_collision", 3, 2'b10);
        applyStimulus("collision_next_cycle", 0, 1, 1, 32'h0C, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            applyStimulus("random", 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 255)) << 2,
                          kind != 0, kind == 1 || kind == 2, kind == 3,
                          32'($urandom_range(0, 255)) << 2,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        checkTable("random_table");
        checkStats("random_stats");

        #3;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkTable("midcycle_reset_table");
        checkStats("midcycle_reset_stats");
        checkOutput("midcycle_reset_idle", 2'b00, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        applyStimulus("post_reset_id", 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        applyStimulus("post_reset_ex", 0, 0, 0, 0, 1, 1, 0, 32'h24, 0, 0);
        checkTable("post_reset_table");
        checkStats("post_reset_stats");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
